// File: rtl/tilegame_pkg.sv
// tilegame_pkg
//   Shared definitions for the tile-game slice: board size, tile index width,
//   clock rate and debounce period, plus the game-mode and in-game state codes
//   used by the game FSM.
package tilegame_pkg;

    localparam int N_TILES       = 10;
    localparam int TILE_IDX_W    = 4;
    localparam int CLK_HZ        = 50_000_000;
    localparam int DEBOUNCE_20MS = CLK_HZ / 50;

    // Top-level game mode
    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_PLAY = 2'd1,
        MODE_WIN  = 2'd2,
        MODE_QUIT = 2'd3
    } game_mode_e;

    // In-game turn state
    typedef enum logic [1:0] {
        PLAY_WAIT_FIRST  = 2'd0,
        PLAY_WAIT_SECOND = 2'd1,
        PLAY_SHOW        = 2'd2,
        PLAY_CHECK       = 2'd3
    } play_state_e;

endpackage

// File: rtl/tile_select_encoder_sel_fifo.sv
// sel_fifo
//   Small power-of-two FIFO whose head is held in output registers, so the
//   valid/data outputs never depend combinationally on the consumer's ready.
// Ports
//   clk        in   1      clock
//   rst        in   1      asynchronous reset, active-high
//   flush      in   1      synchronous flush; a coincident push is discarded
//   push       in   1      write request
//   push_data  in   WIDTH  write data
//   ready      in   1      consumer ready; pop happens on valid & ready
//   valid      out  1      head entry available
//   head_data  out  WIDTH  head entry, held while valid & !ready
//   ovf        out  1      1-cycle pulse: push dropped because buffer full
module sel_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] head_data,
    output logic             ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_s;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_s;
    logic             valid_r;
    logic             ovf_r;
    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] head_s;
    logic             valid_s;
    logic             full_s;
    logic             pop_s;
    logic             wr_s;
    logic             ovf_s;

    // Next occupancy, pointers and head value; when full, a pop frees the slot a push takes
    always_comb begin
        full_s   = (count_r == CW'(DEPTH));
        pop_s    = valid_r & ready & ~flush;
        wr_s     = push & ~flush & (~full_s | pop_s);
        ovf_s    = push & ~flush & full_s & ~pop_s;
        rd_ptr_s = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
        count_s  = count_r;
        head_s   = {WIDTH{1'b0}};
        if (flush) begin
            count_s = {CW{1'b0}};
        end else begin
            count_s = count_r + CW'(wr_s) - CW'(pop_s);
        end
        valid_s = (count_s != {CW{1'b0}});
        // The new head may be the entry being written this very cycle
        if (!valid_s) begin
            head_s = {WIDTH{1'b0}};
        end else if (wr_s && (wr_ptr_r == rd_ptr_s)) begin
            head_s = push_data;
        end else begin
            head_s = mem_r[rd_ptr_s];
        end
    end

    // Storage, pointers and registered head/status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            valid_r  <= 1'b0;
            head_r   <= {WIDTH{1'b0}};
            ovf_r    <= 1'b0;
        end else begin
            if (flush) begin
                rd_ptr_r <= {AW{1'b0}};
                wr_ptr_r <= {AW{1'b0}};
            end else begin
                rd_ptr_r <= rd_ptr_s;
                if (wr_s) begin
                    mem_r[wr_ptr_r] <= push_data;
                    wr_ptr_r        <= wr_ptr_r + AW'(1);
                end else begin
                    wr_ptr_r <= wr_ptr_r;
                end
            end
            count_r <= count_s;
            valid_r <= valid_s;
            head_r  <= head_s;
            ovf_r   <= ovf_s;
        end
    end

    assign valid     = valid_r;
    assign head_data = head_r;
    assign ovf       = ovf_r;

endmodule

// File: rtl/tile_select_encoder.sv
// tile_select_encoder
//   Producer side of the player tile-select channel. Synchronises and
//   debounces the slide switches, detects single 0->1 flips on unlocked tiles,
//   encodes each accepted flip to a tile index and queues it on a
//   valid/ready channel towards the game FSM.
// Ports
//   CLOCK_50     in   1      system clock
//   resetn       in   1      asynchronous reset, active-high (asserted = 1)
//   sw_raw       in   N_SW   raw switch inputs, asynchronous
//   tile_locked  in   N_SW   1 = tile already matched, flips ignored
//   clear        in   1      synchronous flush of buffered events
//   sel_ready    in   1      consumer ready
//   sel_valid    out  1      event available
//   sel_idx      out  4      tile index of head event
//   sw_stable    out  N_SW   debounced switch levels
//   sel_err      out  1      1-cycle pulse: several flips in one tick, all dropped
//   sel_ovf      out  1      1-cycle pulse: event dropped, buffer full
module tile_select_encoder
    import tilegame_pkg::*;
#(
    parameter int N_SW            = N_TILES,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
    parameter int FIFO_DEPTH      = 2
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic [N_SW-1:0]       sw_raw,
    input  logic [N_SW-1:0]       tile_locked,
    input  logic                  clear,
    input  logic                  sel_ready,
    output logic                  sel_valid,
    output logic [TILE_IDX_W-1:0] sel_idx,
    output logic [N_SW-1:0]       sw_stable,
    output logic                  sel_err,
    output logic                  sel_ovf
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int PC_W  = $clog2(N_SW + 1);

    function automatic logic [PC_W-1:0] popcount(input logic [N_SW-1:0] v);
        logic [PC_W-1:0] c;
        c = {PC_W{1'b0}};
        for (int i = 0; i < N_SW; i++) begin
            c = c + PC_W'(v[i]);
        end
        return c;
    endfunction

    // Only meaningful for a one-hot argument
    function automatic logic [TILE_IDX_W-1:0] onehot_to_idx(input logic [N_SW-1:0] v);
        logic [TILE_IDX_W-1:0] idx;
        idx = {TILE_IDX_W{1'b0}};
        for (int i = 0; i < N_SW; i++) begin
            idx = idx | (v[i] ? TILE_IDX_W'(i) : {TILE_IDX_W{1'b0}});
        end
        return idx;
    endfunction

    logic [N_SW-1:0]       sync1_r;
    logic [N_SW-1:0]       sync2_r;
    logic [N_SW-1:0]       sample_r;
    logic [N_SW-1:0]       stable_r;
    logic [N_SW-1:0]       stable_prev_r;
    logic [N_SW-1:0]       rise_r;
    logic [N_SW-1:0]       agree_s;
    logic [N_SW-1:0]       stable_s;
    logic [CNT_W-1:0]      cnt_r;
    logic                  tick_s;
    logic [PC_W-1:0]       rise_cnt_s;
    logic                  push_s;
    logic                  err_s;
    logic [TILE_IDX_W-1:0] push_idx_s;
    logic                  sel_err_r;

    // Sample tick, debounce update rule and flip classification
    always_comb begin
        tick_s     = (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1));
        // A bit is accepted only when two consecutive tick samples agree
        agree_s    = ~(sync2_r ^ sample_r);
        stable_s   = (sample_r & agree_s) | (stable_r & ~agree_s);
        rise_cnt_s = popcount(rise_r);
        push_s     = (rise_cnt_s == PC_W'(1));
        err_s      = (rise_cnt_s > PC_W'(1));
        push_idx_s = onehot_to_idx(rise_r);
    end

    // Two-flop synchroniser, tick counter, debounce and edge registers
    always_ff @(posedge CLOCK_50 or posedge resetn) begin
        if (resetn) begin
            sync1_r       <= {N_SW{1'b0}};
            sync2_r       <= {N_SW{1'b0}};
            cnt_r         <= {CNT_W{1'b0}};
            sample_r      <= {N_SW{1'b0}};
            stable_r      <= {N_SW{1'b0}};
            stable_prev_r <= {N_SW{1'b0}};
            rise_r        <= {N_SW{1'b0}};
            sel_err_r     <= 1'b0;
        end else begin
            sync1_r <= sw_raw;
            sync2_r <= sync1_r;
            if (tick_s) begin
                cnt_r    <= {CNT_W{1'b0}};
                sample_r <= sync2_r;
                stable_r <= stable_s;
            end else begin
                cnt_r    <= cnt_r + CNT_W'(1);
                sample_r <= sample_r;
                stable_r <= stable_r;
            end
            // stable_prev_r lags stable_r by one cycle, so a rise shows for exactly one cycle
            stable_prev_r <= stable_r;
            rise_r        <= stable_r & ~stable_prev_r & ~tile_locked;
            sel_err_r     <= err_s;
        end
    end

    sel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (TILE_IDX_W)
    ) u_sel_fifo (
        .clk       (CLOCK_50),
        .rst       (resetn),
        .flush     (clear),
        .push      (push_s),
        .push_data (push_idx_s),
        .ready     (sel_ready),
        .valid     (sel_valid),
        .head_data (sel_idx),
        .ovf       (sel_ovf)
    );

    assign sw_stable = stable_r;
    assign sel_err   = sel_err_r;

endmodule
